nexys_video_harness: RTL and testbench
======================================

Name: nexys_video_harness

Overview:
- Board-level capture harness for the Nexys Video FPGA.
- Receives two 4-lane serial ADC/radar streams over LVDS-style pin pairs, deserializes each lane into 16-bit words, and emits one 64-bit sample per chip per word period.
- Counts words into FFT-sized frames, tracks lock and error status on eight board LEDs, and registers a UART loopback.
- Single clock domain: all LVDS pins are sampled as single-data-rate on the sys_clock rising edge.

Parameters:
- FFTSIZE, 256, words per frame; the word counter wraps and out*_last asserts at FFTSIZE-1.
- DATAWIDTH, 16, bits per lane word; must be even and at least 4.
- LOCK_WORDS, 2, consecutive good words required to assert lock.

Ports:
- sys_clock  in  1  sole clock; every sequential element uses its rising edge.
- reset  in  1  synchronous, active-high reset.
- top_io_2_lvds_clk_p/_n  in  1 each  chip0 forwarded clock; sampled only for the diff check.
- top_io_2_lvds_data_p/_n  in  4 each  chip0 serial data lanes 3..0.
- top_io_2_lvds_valid_p/_n  in  1 each  chip0 lane-valid qualifier.
- top_io_2_lvds_frame_clk_p/_n  in  1 each  chip0 word framing; high for the first DATAWIDTH/2 bits of a word.
- top_io_3_lvds_*  in  same set  chip1, identical semantics.
- out0_data  out  4*DATAWIDTH  chip0 word, ordered {lane3,lane2,lane1,lane0}.
- out0_valid  out  1  one-cycle strobe marking out0_data valid.
- out0_last  out  1  high with out0_valid on the final word of a frame.
- out1_data / out1_valid / out1_last  out  same widths  chip1 equivalents.
- uart_rxd  in  1  UART receive pin.
- uart_txd  out  1  UART transmit pin.
- led_0..led_7  out  1 each  status LEDs.

Behaviour:
- Only _p pins carry data. _n pins are used solely by the optional diff check.
- Reset values: all out* signals 0, all LEDs 0, uart_txd 1.
- Reset clears all counters and shift registers.
- Reset asserted mid-word discards the partial word; no output strobe follows it.
- Per-channel state machine: IDLE, SHIFT.
- IDLE: wait for a word start, defined as valid=1 and frame=1 in a cycle where the previous sampled frame was 0 or the previous valid was 0.
  - On a word start, capture bit 0 into position 0 of every lane and go to SHIFT with bitcnt=1.
- SHIFT: each cycle with valid=1, place the lane bit at position bitcnt (LSB first) and increment bitcnt.
- Frame check: frame must be 1 while bitcnt < DATAWIDTH/2 and 0 otherwise.
  - On mismatch: set sticky frame error, clear lock, drop the partial word, go to IDLE.
- valid=0 during SHIFT: drop the partial word, go to IDLE. No error is raised.
- Word complete (bit DATAWIDTH-1 captured):
  - The next cycle, out*_valid=1 for exactly one cycle with the assembled word (1-cycle latency after the last bit).
  - bitcnt wraps to 0 and the FSM stays in SHIFT, so back-to-back words need no gap.
- Word counter: 0..FFTSIZE-1, incremented per emitted word.
  - out*_last=1 when the counter equals FFTSIZE-1; the counter then wraps to 0.
  - The counter is cleared on any frame error or valid drop.
- Lock: set after LOCK_WORDS consecutive good words; cleared by any error or by valid=0 while locked.
- The two channels are fully independent; simultaneous outputs on both are legal.
- LEDs:
  - led_0/led_1: chip0/chip1 lock.
  - led_2/led_3: toggle on each out0_last/out1_last.
  - led_4/led_5: chip0/chip1 sticky error, cleared only by reset.
  - led_6: heartbeat, bit 26 of a free-running counter.
  - led_7: constant 1 after reset.
- uart_txd: uart_rxd registered through two flops (loopback).

Optional Feature:
- Macro: LVDS_DIFF_CHECK_EN.
- With the macro defined: any sampled pair with p==n (data, valid, frame or clk) during SHIFT is treated as a frame error for that channel.
- Without the macro: _n pins are ignored entirely and are left unconnected after synthesis.

Test Plan:
- Chip0 stream of 256 words, lane L word k = {0xA0+L, (k<<L)[7:0]}, LSB first, frame high for bits 0-7 -> out0_data word0 = 0xA300_A200_A100_A000, word1 = 0xA308_A204_A102_A001; 256 strobes; out0_last only on word 255; led_2 toggles once; led_0=1 after word 1.
- Chip1 lane L word k = {(k<<L)[7:0], 0x50+L}, driven concurrently with chip0 -> out1_data word3 = 0x1853_0C52_0651_0350; chip0 results unchanged.
- Frame forced high at bit 9 of word 5 -> no word 5 strobe, led_4=1 sticky, led_0=0, word counter restarts from 0 at the next frame rise.
- valid dropped at bit 7 -> partial word discarded, no error, resumes cleanly on the next frame rise.
- Reset pulse mid-word -> all outputs 0, uart_txd=1, no stray strobe; uart_rxd toggle reappears on uart_txd 2 cycles later.
- With LVDS_DIFF_CHECK_EN, data_n_2 held equal to data_p_2 -> frame error, led_4=1.

Source files
------------

// File: rtl/nexys_video_harness.sv
// Nexys Video capture harness: two 4-lane LVDS deserializers with frame counting, status LEDs and UART loopback.
// Build option LVDS_DIFF_CHECK_EN: any sampled p==n pin pair during a word counts as a framing error.

// state   | meaning
// S_IDLE  | waiting for a word start (valid high, frame rising or valid just returned)
// S_SHIFT | assembling lane bits LSB first; bitcnt is the next bit position
module nvh_channel #(
   parameter int FFTSIZE    = 256,
   parameter int DATAWIDTH  = 16,
   parameter int LOCK_WORDS = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [3:0]             data,
   input  logic                   valid,
   input  logic                   frame,
   input  logic                   diff_err,
   output logic [4*DATAWIDTH-1:0] out_data,
   output logic                   out_valid,
   output logic                   out_last,
   output logic                   locked,
   output logic                   err_sticky
);
   localparam int BW = $clog2(DATAWIDTH);
   localparam int CW = (FFTSIZE > 1) ? $clog2(FFTSIZE) : 1;
   localparam int LW = $clog2(LOCK_WORDS + 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATAWIDTH - 1);
   localparam logic [BW-1:0] HALF_BITS = BW'(DATAWIDTH / 2);
   localparam logic [CW-1:0] LAST_WORD = CW'(FFTSIZE - 1);
   localparam logic [LW-1:0] LOCK_PRE  = LW'(LOCK_WORDS - 1);
   localparam logic [LW-1:0] LOCK_MAX  = LW'(LOCK_WORDS);

   typedef enum logic {S_IDLE, S_SHIFT} state_t;

   state_t                        state, state_next;
   logic                          prev_frame, prev_valid;
   logic [BW-1:0]                 bitcnt, bit_pos;
   logic [CW-1:0]                 word_cnt;
   logic [LW-1:0]                 good_cnt;
   logic [3:0][DATAWIDTH-1:0]     lane_q, lane_next;
   logic                          word_start, frame_bad, drop, capture, word_done, abort;

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (word_start) state_next = S_SHIFT;
         S_SHIFT: if (frame_bad || !valid) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      word_start = valid && frame && (!prev_frame || !prev_valid);
      bit_pos    = (state == S_IDLE) ? '0 : bitcnt;
      // Framing is high for the first half of every word, including bit 0 of back-to-back words.
      frame_bad  = (state == S_SHIFT) && (diff_err || (valid && (frame != (bitcnt < HALF_BITS))));
      drop       = (state == S_SHIFT) && !valid && !frame_bad;
      abort      = frame_bad || drop;
      capture    = ((state == S_IDLE) && word_start) || ((state == S_SHIFT) && valid && !frame_bad);
      word_done  = capture && (bit_pos == LAST_BIT);
      lane_next  = lane_q;
      for (int l = 0; l < 4; l++) lane_next[l][bit_pos] = data[l];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_frame <= 1'b0;
         prev_valid <= 1'b0;
         bitcnt     <= '0;
         lane_q     <= '0;
         word_cnt   <= '0;
         good_cnt   <= '0;
         locked     <= 1'b0;
         err_sticky <= 1'b0;
         out_data   <= '0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
      end else begin
         prev_frame <= frame;
         prev_valid <= valid;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         if (capture) begin
            lane_q <= lane_next;
            bitcnt <= word_done ? '0 : bit_pos + 1'b1;
         end
         if (abort) begin
            bitcnt   <= '0;
            word_cnt <= '0;
            good_cnt <= '0;
            locked   <= 1'b0;
         end
         if (frame_bad) err_sticky <= 1'b1;
         if (!valid) begin
            good_cnt <= '0;
            locked   <= 1'b0;
         end
         if (word_done) begin
            out_valid <= 1'b1;
            out_data  <= lane_next;
            out_last  <= (word_cnt == LAST_WORD);
            word_cnt  <= (word_cnt == LAST_WORD) ? '0 : word_cnt + 1'b1;
            if (good_cnt != LOCK_MAX) good_cnt <= good_cnt + 1'b1;
            locked    <= locked | (good_cnt >= LOCK_PRE);
         end
      end
   end
endmodule

module nexys_video_harness #(
   parameter int FFTSIZE    = 256,
   parameter int DATAWIDTH  = 16,
   parameter int LOCK_WORDS = 2
) (
   input  logic                   sys_clock,
   input  logic                   reset,
   input  logic                   top_io_2_lvds_clk_p,
   input  logic                   top_io_2_lvds_clk_n,
   input  logic [3:0]             top_io_2_lvds_data_p,
   input  logic [3:0]             top_io_2_lvds_data_n,
   input  logic                   top_io_2_lvds_valid_p,
   input  logic                   top_io_2_lvds_valid_n,
   input  logic                   top_io_2_lvds_frame_clk_p,
   input  logic                   top_io_2_lvds_frame_clk_n,
   input  logic                   top_io_3_lvds_clk_p,
   input  logic                   top_io_3_lvds_clk_n,
   input  logic [3:0]             top_io_3_lvds_data_p,
   input  logic [3:0]             top_io_3_lvds_data_n,
   input  logic                   top_io_3_lvds_valid_p,
   input  logic                   top_io_3_lvds_valid_n,
   input  logic                   top_io_3_lvds_frame_clk_p,
   input  logic                   top_io_3_lvds_frame_clk_n,
   output logic [4*DATAWIDTH-1:0] out0_data,
   output logic                   out0_valid,
   output logic                   out0_last,
   output logic [4*DATAWIDTH-1:0] out1_data,
   output logic                   out1_valid,
   output logic                   out1_last,
   input  logic                   uart_rxd,
   output logic                   uart_txd,
   output logic                   led_0,
   output logic                   led_1,
   output logic                   led_2,
   output logic                   led_3,
   output logic                   led_4,
   output logic                   led_5,
   output logic                   led_6,
   output logic                   led_7
);
   logic        diff0, diff1;
   logic        uart_meta;
   logic [26:0] hb_cnt;

`ifdef LVDS_DIFF_CHECK_EN
   assign diff0 = (|(top_io_2_lvds_data_p ~^ top_io_2_lvds_data_n))
                | (top_io_2_lvds_valid_p ~^ top_io_2_lvds_valid_n)
                | (top_io_2_lvds_frame_clk_p ~^ top_io_2_lvds_frame_clk_n)
                | (top_io_2_lvds_clk_p ~^ top_io_2_lvds_clk_n);
   assign diff1 = (|(top_io_3_lvds_data_p ~^ top_io_3_lvds_data_n))
                | (top_io_3_lvds_valid_p ~^ top_io_3_lvds_valid_n)
                | (top_io_3_lvds_frame_clk_p ~^ top_io_3_lvds_frame_clk_n)
                | (top_io_3_lvds_clk_p ~^ top_io_3_lvds_clk_n);
`else
   // Without the pair check the _n pins and forwarded clocks have no load and get trimmed.
   logic unused_n;
   assign unused_n = ^{top_io_2_lvds_clk_p, top_io_2_lvds_clk_n, top_io_2_lvds_data_n,
                       top_io_2_lvds_valid_n, top_io_2_lvds_frame_clk_n,
                       top_io_3_lvds_clk_p, top_io_3_lvds_clk_n, top_io_3_lvds_data_n,
                       top_io_3_lvds_valid_n, top_io_3_lvds_frame_clk_n};
   assign diff0 = 1'b0;
   assign diff1 = 1'b0;
`endif

   nvh_channel #(.FFTSIZE(FFTSIZE), .DATAWIDTH(DATAWIDTH), .LOCK_WORDS(LOCK_WORDS)) u_ch0 (
      .clk(sys_clock), .reset(reset), .data(top_io_2_lvds_data_p), .valid(top_io_2_lvds_valid_p),
      .frame(top_io_2_lvds_frame_clk_p), .diff_err(diff0), .out_data(out0_data),
      .out_valid(out0_valid), .out_last(out0_last), .locked(led_0), .err_sticky(led_4));

   nvh_channel #(.FFTSIZE(FFTSIZE), .DATAWIDTH(DATAWIDTH), .LOCK_WORDS(LOCK_WORDS)) u_ch1 (
      .clk(sys_clock), .reset(reset), .data(top_io_3_lvds_data_p), .valid(top_io_3_lvds_valid_p),
      .frame(top_io_3_lvds_frame_clk_p), .diff_err(diff1), .out_data(out1_data),
      .out_valid(out1_valid), .out_last(out1_last), .locked(led_1), .err_sticky(led_5));

   always_ff @(posedge sys_clock) begin
      if (reset) begin
         uart_meta <= 1'b1;
         uart_txd  <= 1'b1;
         hb_cnt    <= '0;
         led_2     <= 1'b0;
         led_3     <= 1'b0;
         led_7     <= 1'b0;
      end else begin
         uart_meta <= uart_rxd;
         uart_txd  <= uart_meta;
         hb_cnt    <= hb_cnt + 1'b1;
         led_7     <= 1'b1;
         if (out0_valid && out0_last) led_2 <= ~led_2;
         if (out1_valid && out1_last) led_3 <= ~led_3;
      end
   end

   assign led_6 = hb_cnt[26];
endmodule

// File: tb/tb_nexys_video_harness.sv
// Self-checking bench for nexys_video_harness: reference model tracks expected words, frame position and lock.
module tb_nexys_video_harness;
   logic        sys_clock = 1'b0;
   logic        reset = 1'b1;
   logic        c2p = 1'b0, c2n = 1'b1, v2p = 1'b0, v2n = 1'b1, f2p = 1'b0, f2n = 1'b1;
   logic        c3p = 1'b0, c3n = 1'b1, v3p = 1'b0, v3n = 1'b1, f3p = 1'b0, f3n = 1'b1;
   logic [3:0]  d2p = '0, d2n = '1, d3p = '0, d3n = '1;
   logic [63:0] out0_data, out1_data;
   logic        out0_valid, out0_last, out1_valid, out1_last;
   logic        uart_rxd = 1'b1, uart_txd;
   logic        led_0, led_1, led_2, led_3, led_4, led_5, led_6, led_7;

   int          errors = 0, checks = 0;
   logic [65:0] obs0[$], obs1[$], exp0[$], exp1[$];
   int          mcnt[2], mgood[2];
   bit          force_eq = 1'b0;

   nexys_video_harness dut (
      .sys_clock(sys_clock), .reset(reset),
      .top_io_2_lvds_clk_p(c2p), .top_io_2_lvds_clk_n(c2n),
      .top_io_2_lvds_data_p(d2p), .top_io_2_lvds_data_n(d2n),
      .top_io_2_lvds_valid_p(v2p), .top_io_2_lvds_valid_n(v2n),
      .top_io_2_lvds_frame_clk_p(f2p), .top_io_2_lvds_frame_clk_n(f2n),
      .top_io_3_lvds_clk_p(c3p), .top_io_3_lvds_clk_n(c3n),
      .top_io_3_lvds_data_p(d3p), .top_io_3_lvds_data_n(d3n),
      .top_io_3_lvds_valid_p(v3p), .top_io_3_lvds_valid_n(v3n),
      .top_io_3_lvds_frame_clk_p(f3p), .top_io_3_lvds_frame_clk_n(f3n),
      .out0_data(out0_data), .out0_valid(out0_valid), .out0_last(out0_last),
      .out1_data(out1_data), .out1_valid(out1_valid), .out1_last(out1_last),
      .uart_rxd(uart_rxd), .uart_txd(uart_txd),
      .led_0(led_0), .led_1(led_1), .led_2(led_2), .led_3(led_3),
      .led_4(led_4), .led_5(led_5), .led_6(led_6), .led_7(led_7));

   always #5 sys_clock = ~sys_clock;

   always @(negedge sys_clock) begin
      if (out0_valid) obs0.push_back({led_0, out0_last, out0_data});
      if (out1_valid) obs1.push_back({led_1, out1_last, out1_data});
   end

   // Reference model: a frame is 256 words counted since the last break; lock after 2 unbroken words.
   function automatic void model_emit(input int ch, input logic [63:0] w);
      logic [65:0] e;
      mgood[ch]++;
      e = {1'(mgood[ch] >= 2), 1'(mcnt[ch] == 255), w};
      mcnt[ch] = (mcnt[ch] + 1) % 256;
      if (ch == 0) exp0.push_back(e);
      else         exp1.push_back(e);
   endfunction

   function automatic void model_abort(input int ch);
      mcnt[ch]  = 0;
      mgood[ch] = 0;
   endfunction

   function automatic logic [63:0] pat0(input int k);
      logic [63:0] w;
      for (int l = 0; l < 4; l++) w[l*16 +: 16] = {8'hA0 + 8'(l), 8'(k << l)};
      return w;
   endfunction

   function automatic logic [63:0] pat1(input int k);
      logic [63:0] w;
      for (int l = 0; l < 4; l++) w[l*16 +: 16] = {8'(k << l), 8'h50 + 8'(l)};
      return w;
   endfunction

   task automatic set_pins(input int ch, input logic [3:0] d, input logic v, input logic f);
      if (ch == 0) begin
         d2p = d; d2n = ~d;
         if (force_eq) d2n[2] = d[2];
         v2p = v; v2n = ~v; f2p = f; f2n = ~f; c2p = ~c2p; c2n = ~c2p;
      end else begin
         d3p = d; d3n = ~d; v3p = v; v3n = ~v; f3p = f; f3n = ~f; c3p = ~c3p; c3n = ~c3p;
      end
   endtask

   // fhi >= 8 forces frame high at that bit; drop >= 0 deasserts valid at that bit.
   task automatic send_word(input int ch, input logic [63:0] w, input int fhi, input int drop);
      logic [3:0] d;
      for (int b = 0; b < 16; b++) begin
         @(negedge sys_clock);
         if (b == drop) begin
            set_pins(ch, 4'h0, 1'b0, 1'b0);
            model_abort(ch);
            return;
         end
         for (int l = 0; l < 4; l++) d[l] = w[l*16 + b];
         set_pins(ch, d, 1'b1, (b < 8) || (b == fhi));
      end
      if (fhi >= 0 || (force_eq && ch == 0)) model_abort(ch);
      else model_emit(ch, w);
   endtask

   task automatic idle(input int ch, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge sys_clock);
         set_pins(ch, 4'h0, 1'b0, 1'b0);
      end
      model_abort(ch);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge sys_clock);
      checks++;
      if ({out0_data, out0_valid, out0_last, out1_data, out1_valid, out1_last} !== '0) begin
         errors++; $display("FAIL reset_outputs got %h/%b%b %h/%b%b want all zero",
                            out0_data, out0_valid, out0_last, out1_data, out1_valid, out1_last);
      end
      checks++;
      if ({led_7, led_6, led_5, led_4, led_3, led_2, led_1, led_0} !== 8'h00) begin
         errors++; $display("FAIL reset_leds got %b want 00000000",
                            {led_7, led_6, led_5, led_4, led_3, led_2, led_1, led_0});
      end
      checks++;
      if (uart_txd !== 1'b1) begin errors++; $display("FAIL reset_txd got %b want 1", uart_txd); end
      reset = 1'b0;
      model_abort(0); model_abort(1);
      @(negedge sys_clock);
      checks++;
      if (led_7 !== 1'b1) begin errors++; $display("FAIL led7_after_reset got %b want 1", led_7); end
   endtask

   task automatic test_stream();
      logic [65:0] o[$], e[$];
      fork
         begin for (int k = 0; k < 256; k++) send_word(0, pat0(k), -1, -1); idle(0, 4); end
         begin for (int k = 0; k < 8; k++) send_word(1, pat1(k), -1, -1); idle(1, 4); end
      join
      checks++;
      if (obs0.size() < 2 || obs0[0][63:0] !== 64'hA300_A200_A100_A000 || obs0[1][63:0] !== 64'hA308_A204_A102_A001) begin
         errors++; $display("FAIL stream_word01 got %0d strobes, w0=%h w1=%h want A300A200A100A000/A308A204A102A001",
                            obs0.size(), obs0.size() > 0 ? obs0[0][63:0] : 64'h0, obs0.size() > 1 ? obs0[1][63:0] : 64'h0);
      end
      checks++;
      if (obs1.size() < 4 || obs1[3][63:0] !== 64'h1853_0C52_0651_0350) begin
         errors++; $display("FAIL stream_chip1_word3 got %h want 18530c5206510350", obs1.size() > 3 ? obs1[3][63:0] : 64'h0);
      end
      checks++;
      if (led_2 !== 1'b1 || led_3 !== 1'b0) begin
         errors++; $display("FAIL stream_led23 got %b%b want 10", led_2, led_3);
      end
      checks++;
      if (led_0 !== 1'b0) begin errors++; $display("FAIL stream_lock_after_idle got %b want 0", led_0); end
      for (int c = 0; c < 2; c++) begin
         if (c == 0) begin o = obs0; e = exp0; end else begin o = obs1; e = exp1; end
         checks++;
         if (o.size() != e.size()) begin errors++; $display("FAIL stream ch%0d strobes got %0d want %0d", c, o.size(), e.size()); end
         for (int i = 0; i < e.size() && i < o.size(); i++) begin
            checks++;
            if (o[i] !== e[i]) begin errors++; $display("FAIL stream ch%0d word%0d got lock/last/data %h want %h", c, i, o[i], e[i]); end
         end
      end
      obs0.delete(); obs1.delete(); exp0.delete(); exp1.delete();
   endtask

   task automatic test_valid_drop();
      for (int k = 0; k < 10; k++) send_word(0, pat0(k), -1, (k == 4) ? 7 : -1);
      idle(0, 4);
      checks++;
      if (led_4 !== 1'b0) begin errors++; $display("FAIL drop_no_error got led_4=%b want 0", led_4); end
      checks++;
      if (obs0.size() != exp0.size()) begin errors++; $display("FAIL drop strobes got %0d want %0d", obs0.size(), exp0.size()); end
      for (int i = 0; i < exp0.size() && i < obs0.size(); i++) begin
         checks++;
         if (obs0[i] !== exp0[i]) begin errors++; $display("FAIL drop word%0d got %h want %h", i, obs0[i], exp0[i]); end
      end
      obs0.delete(); exp0.delete();
   endtask

   task automatic rand_stream(input int ch);
      for (int b = 0; b < 6; b++) begin
         int n = $urandom_range(1, 8);
         for (int k = 0; k < n; k++) send_word(ch, {$urandom, $urandom}, -1, -1);
         idle(ch, $urandom_range(1, 5));
      end
   endtask

   task automatic test_random();
      logic [65:0] o[$], e[$];
      fork
         rand_stream(0);
         rand_stream(1);
      join
      idle(0, 2);
      for (int c = 0; c < 2; c++) begin
         if (c == 0) begin o = obs0; e = exp0; end else begin o = obs1; e = exp1; end
         checks++;
         if (o.size() != e.size()) begin errors++; $display("FAIL random ch%0d strobes got %0d want %0d", c, o.size(), e.size()); end
         for (int i = 0; i < e.size() && i < o.size(); i++) begin
            checks++;
            if (o[i] !== e[i]) begin errors++; $display("FAIL random ch%0d word%0d got %h want %h", c, i, o[i], e[i]); end
         end
      end
      checks++;
      if (led_4 !== 1'b0 || led_5 !== 1'b0) begin errors++; $display("FAIL random_errleds got %b%b want 00", led_4, led_5); end
      obs0.delete(); obs1.delete(); exp0.delete(); exp1.delete();
   endtask

   task automatic test_frame_error();
      for (int k = 0; k < 6; k++) send_word(0, pat0(k), (k == 5) ? 9 : -1, -1);
      checks++;
      if (led_4 !== 1'b1 || led_0 !== 1'b0) begin
         errors++; $display("FAIL frame_err_leds got led_4=%b led_0=%b want 1 0", led_4, led_0);
      end
      for (int k = 6; k < 262; k++) send_word(0, pat0(k), -1, -1);
      idle(0, 4);
      checks++;
      if (led_4 !== 1'b1 || led_5 !== 1'b0) begin errors++; $display("FAIL frame_err_sticky got %b%b want 10", led_4, led_5); end
      checks++;
      if (obs0.size() != exp0.size()) begin errors++; $display("FAIL frame_err strobes got %0d want %0d", obs0.size(), exp0.size()); end
      for (int i = 0; i < exp0.size() && i < obs0.size(); i++) begin
         checks++;
         if (obs0[i] !== exp0[i]) begin errors++; $display("FAIL frame_err word%0d got %h want %h", i, obs0[i], exp0[i]); end
      end
      obs0.delete(); exp0.delete();
   endtask

   task automatic test_reset_midword();
      logic [63:0] w0 = pat0(3), w1 = pat1(3);
      for (int b = 0; b < 8; b++) begin
         @(negedge sys_clock);
         set_pins(0, {w0[48+b], w0[32+b], w0[16+b], w0[b]}, 1'b1, 1'b1);
         set_pins(1, {w1[48+b], w1[32+b], w1[16+b], w1[b]}, 1'b1, 1'b1);
      end
      @(negedge sys_clock);
      reset = 1'b1;
      set_pins(0, 4'h0, 1'b0, 1'b0); set_pins(1, 4'h0, 1'b0, 1'b0);
      @(negedge sys_clock);
      checks++;
      if ({out0_data, out0_valid, out0_last, out1_data, out1_valid, out1_last} !== '0 || uart_txd !== 1'b1) begin
         errors++; $display("FAIL midreset_outputs got %h %b%b %h %b%b txd=%b want zeros txd=1",
                            out0_data, out0_valid, out0_last, out1_data, out1_valid, out1_last, uart_txd);
      end
      checks++;
      if ({led_7, led_6, led_5, led_4, led_3, led_2, led_1, led_0} !== 8'h00) begin
         errors++; $display("FAIL midreset_leds got %b want 00000000", {led_7, led_6, led_5, led_4, led_3, led_2, led_1, led_0});
      end
      @(negedge sys_clock);
      reset = 1'b0;
      model_abort(0); model_abort(1);
      repeat (6) @(negedge sys_clock);
      checks++;
      if (obs0.size() != 0 || obs1.size() != 0) begin
         errors++; $display("FAIL midreset_stray got %0d/%0d strobes want 0/0", obs0.size(), obs1.size());
      end
      checks++;
      if ({led_7, led_6, led_5, led_4, led_3, led_2, led_1, led_0} !== 8'h80) begin
         errors++; $display("FAIL midreset_leds_after got %b want 10000000", {led_7, led_6, led_5, led_4, led_3, led_2, led_1, led_0});
      end
      obs0.delete(); obs1.delete();
   endtask

   task automatic test_uart();
      logic prev_rx, v;
      for (int i = 0; i < 8; i++) begin
         prev_rx = uart_rxd;
         v = (i % 2 == 0) ? ~uart_rxd : 1'($urandom);
         @(negedge sys_clock);
         uart_rxd = v;
         @(negedge sys_clock);
         checks++;
         if (uart_txd !== prev_rx) begin errors++; $display("FAIL uart_1cyc got %b want %b", uart_txd, prev_rx); end
         @(negedge sys_clock);
         checks++;
         if (uart_txd !== v) begin errors++; $display("FAIL uart_2cyc got %b want %b", uart_txd, v); end
      end
   endtask

`ifdef LVDS_DIFF_CHECK_EN
   task automatic test_diff();
      force_eq = 1'b1;
      send_word(0, pat0(1), -1, -1);
      force_eq = 1'b0;
      idle(0, 4);
      checks++;
      if (led_4 !== 1'b1 || obs0.size() != 0) begin
         errors++; $display("FAIL diff_check got led_4=%b strobes=%0d want 1 0", led_4, obs0.size());
      end
      obs0.delete(); exp0.delete();
   endtask
`endif

   initial begin
      test_reset();
      test_stream();
      test_valid_drop();
      test_random();
      test_frame_error();
      test_reset_midword();
      test_uart();
`ifdef LVDS_DIFF_CHECK_EN
      test_diff();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
